// File: rtl/ro_odometer_ctrl.sv
// Ring-oscillator odometer: fresh measurement, stress, settle, aged measurement, delta.
// Define RO_SYNC_EN to pass ro_out through a two-flop synchronizer before edge detection.
module ro_odometer_ctrl #(
   parameter int CNT_W      = 16,
   parameter int TMR_W      = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [TMR_W-1:0] gate_cycles,
   input  logic [TMR_W-1:0] stress_cycles,
   input  logic             ro_out,
   output logic             en_ro,
   output logic             en_trans,
   output logic             nmos_g,
   output logic             ro_sleep,
   output logic [CNT_W-1:0] fresh_cnt,
   output logic [CNT_W-1:0] aged_cnt,
   output logic [CNT_W-1:0] delta,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE, S_MEAS_FRESH, S_STRESS, S_SETTLE, S_MEAS_AGED, S_DONE
   } state_t;

   // Mode codes as {ro_sleep, en_ro, en_trans, nmos_g}.
   localparam logic [3:0] MODE_INIT    = 4'b1010;
   localparam logic [3:0] MODE_MEASURE = 4'b1110;
   localparam logic [3:0] MODE_SLEEP   = 4'b0000;
   localparam logic [3:0] MODE_STRESS  = 4'b1001;

   localparam logic [TMR_W-1:0] SETTLE_LAST =
      (SETTLE_CYC > 1) ? TMR_W'(SETTLE_CYC - 1) : '0;

   state_t           state, state_n;
   logic [TMR_W-1:0] tmr, tmr_n;
   logic [TMR_W-1:0] gate_q, gate_n;
   logic [TMR_W-1:0] stress_q, stress_n;
   logic [CNT_W-1:0] fresh_n, aged_n, delta_n;
   logic [3:0]       mode_q;
   logic             ro_q, ro_d, rise;

   // A zero length still yields a one-cycle window, so the last tick index is max(len,1)-1.
   function automatic logic [TMR_W-1:0] last_tick(input logic [TMR_W-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

   function automatic logic [3:0] mode_of(input state_t s);
      case (s)
         S_MEAS_FRESH, S_MEAS_AGED: return MODE_MEASURE;
         S_STRESS:                  return MODE_STRESS;
         S_DONE:                    return MODE_SLEEP;
         default:                   return MODE_INIT;
      endcase
   endfunction

`ifdef RO_SYNC_EN
   logic ro_meta;
   always_ff @(posedge clk) begin
      if (rst) begin
         ro_meta <= 1'b0;
         ro_q    <= 1'b0;
         ro_d    <= 1'b0;
      end else begin
         ro_meta <= ro_out;
         ro_q    <= ro_meta;
         ro_d    <= ro_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         ro_q <= 1'b0;
         ro_d <= 1'b0;
      end else begin
         ro_q <= ro_out;
         ro_d <= ro_q;
      end
   end
`endif

   assign rise = ro_q & ~ro_d;

   // NOTE: every variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_n  = state;
      tmr_n    = tmr;
      gate_n   = gate_q;
      stress_n = stress_q;
      fresh_n  = fresh_cnt;
      aged_n   = aged_cnt;
      delta_n  = delta;
      case (state)
         S_IDLE: begin
            if (start) begin
               gate_n   = gate_cycles;
               stress_n = stress_cycles;
               fresh_n  = '0;
               aged_n   = '0;
               delta_n  = '0;
               tmr_n    = last_tick(gate_cycles);
               state_n  = S_MEAS_FRESH;
            end
         end
         S_MEAS_FRESH: begin
            if (rise && !(&fresh_cnt)) fresh_n = fresh_cnt + 1'b1;
            if (tmr == '0) begin
               tmr_n   = last_tick(stress_q);
               state_n = S_STRESS;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         S_STRESS: begin
            if (tmr == '0) begin
               tmr_n   = SETTLE_LAST;
               state_n = S_SETTLE;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         S_SETTLE: begin
            if (tmr == '0) begin
               tmr_n   = last_tick(gate_q);
               state_n = S_MEAS_AGED;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         S_MEAS_AGED: begin
            if (rise && !(&aged_cnt)) aged_n = aged_cnt + 1'b1;
            if (tmr == '0) begin
               // Uses the final aged count so delta is valid alongside the done pulse.
               delta_n = (fresh_cnt > aged_n) ? fresh_cnt - aged_n : '0;
               tmr_n   = '0;
               state_n = S_DONE;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (abort) begin
         state_n = S_IDLE;
         tmr_n   = '0;
         fresh_n = fresh_cnt;
         aged_n  = aged_cnt;
         delta_n = delta;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tmr       <= '0;
         gate_q    <= '0;
         stress_q  <= '0;
         fresh_cnt <= '0;
         aged_cnt  <= '0;
         delta     <= '0;
         mode_q    <= MODE_INIT;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         tmr       <= tmr_n;
         gate_q    <= gate_n;
         stress_q  <= stress_n;
         fresh_cnt <= fresh_n;
         aged_cnt  <= aged_n;
         delta     <= delta_n;
         mode_q    <= mode_of(state_n);
         busy      <= (state_n != S_IDLE) && (state_n != S_DONE);
         done      <= (state_n == S_DONE);
      end
   end

   assign {ro_sleep, en_ro, en_trans, nmos_g} = mode_q;

endmodule

// File: tb/tb_ro_odometer_ctrl.sv
// Scoreboard bench for ro_odometer_ctrl: runs push expected results, a monitor checks them on done.
module tb_ro_odometer_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort, ro_out;
   logic [15:0] gate_cycles, stress_cycles;
   logic        en_ro, en_trans, nmos_g, ro_sleep, busy, done;
   logic [15:0] fresh_cnt, aged_cnt, delta;
   logic        en_ro4, en_trans4, nmos_g4, ro_sleep4, busy4, done4;
   logic [3:0]  fresh4, aged4, delta4;
   logic [3:0]  mode;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int f_lo, f_hi, a_lo, a_hi, d_lo, d_hi;
      int n_meas, n_stress, n_settle;
   } exp_t;
   exp_t sb[$];

   int n_meas, n_stress, n_settle, n_bad;
   int per_fresh = 0;
   int per_aged  = 0;

   always #5 clk = ~clk;
   assign mode = {ro_sleep, en_ro, en_trans, nmos_g};

   ro_odometer_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .gate_cycles(gate_cycles), .stress_cycles(stress_cycles), .ro_out(ro_out),
      .en_ro(en_ro), .en_trans(en_trans), .nmos_g(nmos_g), .ro_sleep(ro_sleep),
      .fresh_cnt(fresh_cnt), .aged_cnt(aged_cnt), .delta(delta),
      .busy(busy), .done(done)
   );

   ro_odometer_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .gate_cycles(gate_cycles), .stress_cycles(stress_cycles), .ro_out(ro_out),
      .en_ro(en_ro4), .en_trans(en_trans4), .nmos_g(nmos_g4), .ro_sleep(ro_sleep4),
      .fresh_cnt(fresh4), .aged_cnt(aged4), .delta(delta4),
      .busy(busy4), .done(done4)
   );

   task automatic check(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // ro_out driver: toggles every per_* clocks, switching to per_aged once stress has been seen.
   initial begin
      int  tog = 0;
      bit  aged_phase = 0;
      int  per;
      ro_out = 1'b0;
      forever begin
         @(negedge clk);
         if (!busy) aged_phase = 0;
         else if (nmos_g) aged_phase = 1;
         per = aged_phase ? per_aged : per_fresh;
         if (per != 0) begin
            tog++;
            if (tog >= per) begin
               ro_out = ~ro_out;
               tog    = 0;
            end
         end
      end
   end

   // Monitor: tallies mode cycles and checks the scoreboard entry on each done pulse.
   initial begin
      exp_t e;
      n_meas = 0; n_stress = 0; n_settle = 0; n_bad = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            n_meas = 0; n_stress = 0; n_settle = 0; n_bad = 0;
         end else if (done) begin
            check("done_expected", sb.size(), 1, 1000);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("fresh_cnt", int'(fresh_cnt), e.f_lo, e.f_hi);
               check("aged_cnt",  int'(aged_cnt),  e.a_lo, e.a_hi);
               check("delta",     int'(delta),     e.d_lo, e.d_hi);
               check("measure_cycles", n_meas,   e.n_meas,   e.n_meas);
               check("stress_cycles",  n_stress, e.n_stress, e.n_stress);
               check("settle_cycles",  n_settle, e.n_settle, e.n_settle);
            end
            check("bad_mode_cycles", n_bad, 0, 0);
            check("done_mode", int'(mode), 0, 0);
            check("done_busy", int'(busy), 0, 0);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0, 0);
            n_meas = 0; n_stress = 0; n_settle = 0; n_bad = 0;
         end else if (busy) begin
            case (mode)
               4'b1110: n_meas++;
               4'b1001: n_stress++;
               4'b1010: n_settle++;
               default: n_bad++;
            endcase
         end else begin
            n_meas = 0; n_stress = 0; n_settle = 0; n_bad = 0;
         end
      end
   end

   task automatic run_start(input int gate, input int stress, input bit push, input exp_t e);
      @(negedge clk);
      gate_cycles   = 16'(gate);
      stress_cycles = 16'(stress);
      start         = 1'b1;
      if (push) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      check("done_within_budget", int'(got), 1, 1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      exp_t none;
      int   hold;
      int   seen;
      none = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      gate_cycles = '0; stress_cycles = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_mode",  int'(mode), 4'b1010, 4'b1010);
      check("reset_busy",  int'(busy), 0, 0);
      check("reset_done",  int'(done), 0, 0);
      check("reset_fresh", int'(fresh_cnt), 0, 0);
      check("reset_aged",  int'(aged_cnt), 0, 0);
      check("reset_delta", int'(delta), 0, 0);

      // Equal speed: toggle every 5 clocks -> 10 rising edges per 100-cycle window.
      per_fresh = 5; per_aged = 5;
      e = '{9, 11, 9, 11, 0, 1, 200, 50, 4};
      run_start(100, 50, 1, e);
      wait_done(1000);

      // Aged slowdown: 20 edges fresh, 10 edges aged over 200 cycles.
      per_fresh = 5; per_aged = 10;
      e = '{19, 21, 9, 11, 8, 12, 400, 50, 4};
      run_start(200, 50, 1, e);
      wait_done(1000);

      // Second start inside MEAS_FRESH is ignored; abort during STRESS.
      per_fresh = 5; per_aged = 5;
      run_start(40, 60, 0, none);
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (nmos_g) begin
            seen = 1;
            break;
         end
         start = (i == 10);
      end
      start = 1'b0;
      check("abort_reached_stress", seen, 1, 1);
      check("fresh_window_len", n_meas, 40, 40);
      repeat (3) @(negedge clk);
      hold  = int'(fresh_cnt);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_mode",  int'(mode), 4'b1010, 4'b1010);
      check("abort_busy",  int'(busy), 0, 0);
      check("abort_fresh", int'(fresh_cnt), 3, 5);
      check("abort_fresh_hold", int'(fresh_cnt), hold, hold);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) seen++;
         @(negedge clk);
      end
      check("abort_no_done", seen, 0, 0);

      // Reset in the middle of MEAS_AGED, with start held high during the reset edge.
      run_start(30, 10, 0, none);
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (nmos_g) seen = 1;
         if (seen == 1 && mode == 4'b1110) begin
            seen = 2;
            break;
         end
      end
      check("reached_meas_aged", seen, 2, 2);
      repeat (5) @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_mode",  int'(mode), 4'b1010, 4'b1010);
      check("rst_busy",  int'(busy), 0, 0);
      check("rst_done",  int'(done), 0, 0);
      check("rst_fresh", int'(fresh_cnt), 0, 0);
      check("rst_aged",  int'(aged_cnt), 0, 0);
      check("rst_delta", int'(delta), 0, 0);

      // Zero lengths: each timed window lasts one cycle.
      per_fresh = 0; per_aged = 0;
      e = '{0, 0, 0, 0, 0, 0, 2, 1, 4};
      run_start(0, 0, 1, e);
      wait_done(100);

      // Saturation: 30 edges per window; the 4-bit instance must stop at 15.
      per_fresh = 1; per_aged = 1;
      e = '{29, 31, 29, 31, 0, 2, 120, 5, 4};
      run_start(60, 5, 1, e);
      wait_done(500);
      check("sat_fresh4", int'(fresh4), 15, 15);
      check("sat_aged4",  int'(aged4),  15, 15);
      check("sat_delta4", int'(delta4), 0, 0);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ro_odometer_ctrl.md
RO_ODOMETER_CTRL -- requirements
Module: ro_odometer_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of edge counters and result outputs.
REQ-002 Parameter TMR_W, default 16: width of gate and stress cycle timers.
REQ-003 Parameter SETTLE_CYC, default 4: clock cycles held in the init code between stress and the aged measurement.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to run one odometer sequence; sampled only in IDLE.
REQ-007 abort  input  1  return to IDLE on the next edge; done not raised.
REQ-008 gate_cycles  input  TMR_W  measurement window length; latched at accepted start.
REQ-009 stress_cycles  input  TMR_W  stress duration; latched at accepted start.
REQ-010 ro_out  input  1  ring oscillator output, asynchronous to clk.
REQ-011 en_ro, en_trans, nmos_g, ro_sleep  output  1 each  ring oscillator mode controls.
REQ-012 fresh_cnt, aged_cnt  output  CNT_W each  rising-edge counts of the fresh and aged measurements.
REQ-013 delta  output  CNT_W  fresh_cnt minus aged_cnt, floored at 0.
REQ-014 busy  output  1  high in every state except IDLE and DONE.
REQ-015 done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-016 Mode codes {ro_sleep,en_ro,en_trans,nmos_g}: INIT=1010, MEASURE=1110, SLEEP=0000, STRESS=1001.
REQ-017 FSM states are IDLE, MEAS_FRESH, STRESS, SETTLE, MEAS_AGED and DONE; all outputs are registered.
REQ-018 IDLE: drives INIT; start=1 latches both timer inputs, clears both counts and delta, and enters MEAS_FRESH.
REQ-019 MEAS_FRESH: drives MEASURE for exactly max(gate_cycles,1) cycles, counting synchronized ro_out rising edges into fresh_cnt, then enters STRESS.
REQ-020 STRESS: drives STRESS for max(stress_cycles,1) cycles, then enters SETTLE.
REQ-021 SETTLE: drives INIT for SETTLE_CYC cycles, then enters MEAS_AGED.
REQ-022 MEAS_AGED: same window and edge counting as MEAS_FRESH, counting into aged_cnt, then enters DONE.
REQ-023 DONE: drives SLEEP, registers delta, pulses done for one cycle, and returns to IDLE on the next cycle.
REQ-024 Edge counters saturate at all-ones and do not wrap.
REQ-025 start is ignored while busy.
REQ-026 abort has priority over start and over all timer expiry.
REQ-027 abort leaves fresh_cnt, aged_cnt and delta at their current values.
REQ-028 Rising-edge detection compares the synchronized sample with its one-cycle-delayed copy.
REQ-029 Only edges whose detect pulse falls inside the window are counted.

Reset
REQ-030 rst=1 on a clock edge forces IDLE in every state, overriding start and abort.
REQ-031 Reset values: INIT mode code (ro_sleep=1, en_ro=0, en_trans=1, nmos_g=0); counts, delta and timers 0; busy=0; done=0; synchronizer and edge-detect flops 0.

Configuration
REQ-032 With macro RO_SYNC_EN defined, ro_out passes through a two-flop synchronizer before edge detection, so detection latency is 3 cycles.
REQ-033 Without RO_SYNC_EN, ro_out is registered once before edge detection, so detection latency is 2 cycles; for benches that drive ro_out synchronously to clk.

Verification
REQ-034 Fresh measurement: reset, then gate_cycles=100, stress_cycles=50, ro_out toggled every 5 clk, start -> fresh_cnt=10 (±1), aged_cnt=10 (±1), delta=0 or 1, done pulse 1 cycle.
REQ-035 Aged slowdown: toggle every 5 clk during MEAS_FRESH and every 10 clk during MEAS_AGED, gate_cycles=200 -> fresh_cnt=20 (±1), aged_cnt=10 (±1), delta=10 (±2).
REQ-036 Mode codes: check {ro_sleep,en_ro,en_trans,nmos_g} = 1110 in the measure states, 1001 for exactly stress_cycles=50 cycles, 1010 for exactly 4 SETTLE cycles, and 0000 in DONE.
REQ-037 Abort and busy start: a second start in MEAS_FRESH is ignored; abort in STRESS -> IDLE next cycle, mode 1010, done stays 0, fresh_cnt holds.
REQ-038 Reset and saturation: rst mid-MEAS_AGED -> all REQ-031 values after one edge; CNT_W=4 with 30 edges per window -> fresh_cnt=15, no wrap.
REQ-039 Zero lengths: gate_cycles=0 and stress_cycles=0 -> each window lasts 1 cycle, the sequence completes, and done is asserted.
